// File: rtl/ksa_round_key_fetch.sv
// Round-key fetch stage: walks the key-schedule memory and presents 128-bit round keys over valid/ready.
// Optional macro RK_PREFETCH_EN adds a second key buffer so fetching key k+1 overlaps presentation of key k.
module ksa_round_key_fetch (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         key_done,
  input  logic [1:0]   key_size,
  input  logic         E_D,
  output logic [5:0]   ksa_addr,
  input  logic [31:0]  ksa_data,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         busy,
  output logic         err
);

  // Handshake: a key transfers on any rising edge where rk_valid && rk_ready; while rk_valid is
  // high and rk_ready low, rk_data/rk_round/rk_last hold, and rk_valid only falls after a transfer,
  // an abort (key_done low while busy) or reset.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

`ifdef RK_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  state_t       state;
  logic [1:0]   sz;
  logic         enc;

  // Address engine: one key's four word addresses at a time.
  logic         fetch_on;
  logic [1:0]   wcnt;
  logic [3:0]   fetch_round;
  logic [3:0]   next_round;
  logic         fetched_all;

  // Capture pipeline: data arrives one cycle after its address.
  logic         cap_pend;
  logic [1:0]   cap_idx;
  logic [3:0]   cap_round;
  logic [95:0]  asm_q;

  // Buffer slots reserved by keys that are in flight or waiting to be taken.
  logic [1:0]   res_cnt;

`ifdef RK_PREFETCH_EN
  logic         b_valid;
  logic [127:0] b_data;
  logic [3:0]   b_round;
  logic         b_last;
`endif

  function automatic logic [3:0] nr_of(input logic [1:0] s);
    logic [3:0] n;
    case (s)
      2'b00:   n = 4'd10;
      2'b01:   n = 4'd12;
      default: n = 4'd14;
    endcase
    return n;
  endfunction

  // Decrypt walks the schedule backwards, so round r uses key index Nr - r.
  function automatic logic [5:0] key_addr(input logic [3:0] r, input logic [3:0] n, input logic e);
    logic [3:0] k;
    k = e ? r : (n - r);
    return {k, 2'b00};
  endfunction

  logic [3:0]   nr;
  logic [3:0]   start_nr;
  logic         pop;
  logic         push;
  logic [127:0] push_data;
  logic         push_last;
  logic         addr_free;
  logic [1:0]   res_after_pop;
  logic         launch;
  logic         start_ok;
  logic         abort;

  assign nr       = nr_of(sz);
  assign start_nr = nr_of(key_size);
  assign busy     = (state != IDLE);

  always_comb begin
    pop           = rk_valid && rk_ready;
    push          = cap_pend && (cap_idx == 2'd3);
    push_data     = {asm_q, ksa_data};
    push_last     = (cap_round == nr);
    addr_free     = !fetch_on || (wcnt == 2'd3);
    res_after_pop = res_cnt - {1'b0, pop};
    launch        = (state != IDLE) && !fetched_all && addr_free && (res_after_pop < DEPTH);
    start_ok      = start && key_done && (key_size != 2'b11);
    abort         = (state != IDLE) && !key_done;
  end

  always_ff @(posedge CLK) begin
    if (RST || abort) begin
      state       <= IDLE;
      err         <= abort && !RST;
      sz          <= 2'b00;
      enc         <= 1'b0;
      fetch_on    <= 1'b0;
      wcnt        <= 2'd0;
      fetch_round <= 4'd0;
      next_round  <= 4'd0;
      fetched_all <= 1'b0;
      cap_pend    <= 1'b0;
      cap_idx     <= 2'd0;
      cap_round   <= 4'd0;
      asm_q       <= '0;
      res_cnt     <= 2'd0;
      ksa_addr    <= 6'd0;
      rk_valid    <= 1'b0;
      rk_data     <= '0;
      rk_round    <= 4'd0;
      rk_last     <= 1'b0;
`ifdef RK_PREFETCH_EN
      b_valid     <= 1'b0;
      b_data      <= '0;
      b_round     <= 4'd0;
      b_last      <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              sz          <= key_size;
              enc         <= E_D;
              state       <= FETCH;
              fetch_on    <= 1'b1;
              wcnt        <= 2'd0;
              fetch_round <= 4'd0;
              next_round  <= 4'd1;
              fetched_all <= 1'b0;
              cap_pend    <= 1'b0;
              res_cnt     <= 2'd1;
              ksa_addr    <= key_addr(4'd0, start_nr, E_D);
            end else begin
              err <= 1'b1;
            end
          end
        end

        default: begin
          // Address engine: a new key may follow directly behind the last word of the previous one.
          if (launch) begin
            fetch_on    <= 1'b1;
            wcnt        <= 2'd0;
            fetch_round <= next_round;
            ksa_addr    <= key_addr(next_round, nr, enc);
            next_round  <= next_round + 4'd1;
            if (next_round == nr) fetched_all <= 1'b1;
          end else if (fetch_on && (wcnt != 2'd3)) begin
            wcnt     <= wcnt + 2'd1;
            ksa_addr <= ksa_addr + 6'd1;
          end else begin
            fetch_on <= 1'b0;
            ksa_addr <= 6'd0;
          end

          cap_pend  <= fetch_on;
          cap_idx   <= wcnt;
          cap_round <= fetch_round;
          if (cap_pend) begin
            case (cap_idx)
              2'd0:    asm_q[95:64] <= ksa_data;
              2'd1:    asm_q[63:32] <= ksa_data;
              2'd2:    asm_q[31:0]  <= ksa_data;
              default: asm_q        <= asm_q;
            endcase
          end

          res_cnt <= res_cnt - {1'b0, pop} + {1'b0, launch};

`ifdef RK_PREFETCH_EN
          // Two-entry FIFO: the output registers are the head, b_* the tail.
          if (!rk_valid || pop) begin
            if (b_valid) begin
              rk_valid <= 1'b1;
              rk_data  <= b_data;
              rk_round <= b_round;
              rk_last  <= b_last;
              b_valid  <= push;
              if (push) begin
                b_data  <= push_data;
                b_round <= cap_round;
                b_last  <= push_last;
              end
            end else if (push) begin
              rk_valid <= 1'b1;
              rk_data  <= push_data;
              rk_round <= cap_round;
              rk_last  <= push_last;
            end else begin
              rk_valid <= 1'b0;
            end
          end else if (push) begin
            b_valid <= 1'b1;
            b_data  <= push_data;
            b_round <= cap_round;
            b_last  <= push_last;
          end
`else
          // Reservation guarantees the single slot is empty whenever a key completes.
          if (push) begin
            rk_valid <= 1'b1;
            rk_data  <= push_data;
            rk_round <= cap_round;
            rk_last  <= push_last;
          end else if (pop) begin
            rk_valid <= 1'b0;
          end
`endif

          if (launch || (fetch_on && (wcnt != 2'd3))) begin
            state <= FETCH;
          end else if (fetch_on) begin
            state <= DRAIN;
          end else begin
            state <= HOLD;
          end

          // The final key has been taken: the sequence is complete.
          if (pop && rk_last) begin
            state    <= IDLE;
            rk_valid <= 1'b0;
            rk_round <= 4'd0;
            rk_last  <= 1'b0;
            fetch_on <= 1'b0;
            cap_pend <= 1'b0;
            ksa_addr <= 6'd0;
            res_cnt  <= 2'd0;
`ifdef RK_PREFETCH_EN
            b_valid  <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_round_key_fetch.sv
// Self-checking bench for ksa_round_key_fetch: directed sequences, expected-key queue, monitor on handshakes.
module tb_ksa_round_key_fetch;

  localparam int W = 133;  // {last, round[3:0], data[127:0]}
`ifdef RK_PREFETCH_EN
  localparam int LAST_VIS_128 = 45;
`else
  localparam int LAST_VIS_128 = 65;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic         key_done = 1'b0;
  logic [1:0]   key_size = 2'b00;
  logic         E_D = 1'b0;
  logic         rk_ready = 1'b0;
  logic [5:0]   ksa_addr;
  logic [31:0]  ksa_data;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         busy;
  logic         err;

  logic [31:0]  mem [64];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_count = 0;
  int last_vis = -1;
  int e0;

  ksa_round_key_fetch dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .key_done (key_done),
    .key_size (key_size),
    .E_D      (E_D),
    .ksa_addr (ksa_addr),
    .ksa_data (ksa_data),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .rk_last  (rk_last),
    .busy     (busy),
    .err      (err)
  );

  // Clock, cycle counter and a one-cycle-latency schedule memory.
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) ksa_data <= mem[ksa_addr];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rk_valid"}, rk_valid, 0);
    check({tag, "_rk_data"},  rk_data,  0);
    check({tag, "_rk_round"}, rk_round, 0);
    check({tag, "_rk_last"},  rk_last,  0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_err"},      err,      0);
    check({tag, "_ksa_addr"}, ksa_addr, 0);
  endtask

  // Memory holds word n = n, so round key for schedule index k is {4k, 4k+1, 4k+2, 4k+3}.
  task automatic push_seq(input logic [1:0] sz, input logic enc, input int upto);
    int nr;
    int k;
    logic [127:0] d;
    logic [3:0] rr;
    logic lst;
    nr = 10 + 2 * int'(sz);
    for (int r = 0; r <= upto; r++) begin
      k   = enc ? r : nr - r;
      d   = {mem[4*k], mem[4*k+1], mem[4*k+2], mem[4*k+3]};
      rr  = r[3:0];
      lst = (r == nr);
      exp_q.push_back({lst, rr, d});
    end
  endtask

  // Returns at the negedge after the accepting edge E0, with e0 = edge index of E0.
  task automatic start_seq(input logic [1:0] sz, input logic enc, output int e0_out);
    @(posedge CLK); #1;
    key_size = sz; E_D = enc; start = 1'b1;
    hs_count = 0; last_vis = -1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    e0_out = cyc;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!busy) break;
    end
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL %s_timeout: busy got 1 after 400 cycles, expected 0", name);
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (rk_valid) break;
    end
  endtask

  // Monitor: every handshake pops the expected queue and compares.
  always @(negedge CLK) begin
    if (!RST && rk_valid && rk_last && last_vis < 0) last_vis = cyc;
    if (!RST && rk_valid && rk_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_key: got round %0d data %0h, expected no key", rk_round, rk_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("key_data",  rk_data,  mon_e[127:0]);
        check("key_round", rk_round, mon_e[131:128]);
        check("key_last",  rk_last,  mon_e[132]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = i;

    // Reset
    key_done = 1'b1;
    repeat (3) @(posedge CLK);
    check_reset_values("in_reset");
    #1 RST = 1'b0;
    @(negedge CLK);
    check_reset_values("after_reset");

    // AES-128 encrypt, consumer always ready
    rk_ready = 1'b1;
    push_seq(2'b00, 1'b1, 10);
    start_seq(2'b00, 1'b1, e0);
    check("t1_first_addr", ksa_addr, 0);
    check("t1_busy", busy, 1);
    wait_valid();
    check("t1_latency", cyc - e0, 5);
    check("t1_first_data", rk_data, 128'h00000000_00000001_00000002_00000003);
    check("t1_first_round", rk_round, 0);
    wait_idle("t1");
    check("t1_last_visible", last_vis - e0, LAST_VIS_128);
    check("t1_key_count", hs_count, 11);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_valid_idle", rk_valid, 0);

    // AES-256 decrypt: schedule walked from index 14 down to 0
    push_seq(2'b10, 1'b0, 14);
    start_seq(2'b10, 1'b0, e0);
    check("t2_addr0", ksa_addr, 56);
    for (int j = 1; j < 4; j++) begin
      @(negedge CLK);
      check("t2_addr", ksa_addr, 56 + j);
    end
    wait_idle("t2");
    check("t2_key_count", hs_count, 15);
    check("t2_queue_empty", exp_q.size(), 0);

    // Backpressure on AES-192 encrypt; start while busy must be ignored
    rk_ready = 1'b0;
    push_seq(2'b01, 1'b1, 12);
    start_seq(2'b01, 1'b1, e0);
    wait_valid();
    for (int i = 0; i < 7; i++) begin
      @(posedge CLK); #1;
      start = 1'b1;
      @(negedge CLK);
      check("t3_hold_valid", rk_valid, 1);
      check("t3_hold_data", rk_data, 128'h00000000_00000001_00000002_00000003);
      check("t3_hold_round", rk_round, 0);
      check("t3_no_err", err, 0);
`ifndef RK_PREFETCH_EN
      check("t3_hold_addr", ksa_addr, 0);
`endif
    end
    @(posedge CLK); #1;
    start = 1'b0;
    rk_ready = 1'b1;
    wait_idle("t3");
    check("t3_key_count", hs_count, 13);
    check("t3_queue_empty", exp_q.size(), 0);

    // Illegal starts: key_size 11, then key_done low
    @(posedge CLK); #1;
    key_size = 2'b11; E_D = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    check("t4a_err", err, 1);
    check("t4a_busy", busy, 0);
    @(negedge CLK);
    check("t4a_err_once", err, 0);
    check("t4a_busy_after", busy, 0);
    @(posedge CLK); #1;
    key_size = 2'b00; key_done = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    check("t4b_err", err, 1);
    check("t4b_busy", busy, 0);
    @(negedge CLK);
    check("t4b_err_once", err, 0);
    @(posedge CLK); #1;
    key_done = 1'b1;

    // Abort while round 3 is being fetched, then replay from round 0
    push_seq(2'b00, 1'b1, 2);
    start_seq(2'b00, 1'b1, e0);
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (hs_count >= 3) break;
    end
    key_done = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("t5_busy", busy, 0);
    check("t5_valid", rk_valid, 0);
    check("t5_err", err, 1);
    @(negedge CLK);
    check("t5_err_once", err, 0);
    check("t5_keys_before_abort", hs_count, 3);
    check("t5_queue_empty", exp_q.size(), 0);
    @(posedge CLK); #1;
    key_done = 1'b1;
    push_seq(2'b00, 1'b1, 10);
    start_seq(2'b00, 1'b1, e0);
    wait_idle("t5_replay");
    check("t5_replay_count", hs_count, 11);
    check("t5_replay_empty", exp_q.size(), 0);

    // Reset asserted during DRAIN of the first key
    start_seq(2'b00, 1'b1, e0);
    repeat (3) @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_reset_values("t6_reset_drain");
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (8) @(negedge CLK);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_valid", rk_valid, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
